// File: rtl/program_loader.sv
// Byte-stream bootloader: parses a length-prefixed, checksummed word stream,
// writes each assembled big-endian word into program memory and releases the core on success.
module program_loader #(
    parameter int MEMORY_DEPTH = 64,
    parameter int ADDR_WIDTH   = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_Start,
    input  logic        in_ByteValid,
    input  logic [7:0]  in_Byte_8,
    output logic        o_ByteReady,
    output logic        o_MemWrite,
    output logic [31:0] o_MemAddress_dw,
    output logic [31:0] o_MemData_dw,
    output logic        o_CoreReset,
    output logic        o_Busy,
    output logic        o_Done,
    output logic        o_Error
);

    localparam logic [15:0] MAX_LEN = 16'(MEMORY_DEPTH);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_HI = 3'd1,
        LEN_LO = 3'd2,
        DATA   = 3'd3,
        CHECK  = 3'd4,
        DONE   = 3'd5,
        ERROR  = 3'd6
    } state_t;

    state_t                state;
    state_t                stateNext;
    logic [15:0]           wordCount;
    logic [ADDR_WIDTH-1:0] wordIndex;
    logic [1:0]            byteCount;
    logic [23:0]           wordShift;
    logic [7:0]            checksum;

    logic                  byteTake;
    logic                  lastWord;
    logic [15:0]           lenFull;
    logic [7:0]            checkSum;
    logic                  readyNext;
    logic                  busyNext;
    logic                  doneNext;
    logic                  errorNext;
    logic                  coreResetNext;

    assign byteTake = in_ByteValid & o_ByteReady;
    assign lenFull  = {wordCount[15:8], in_Byte_8};
    assign lastWord = (16'(wordIndex) == wordCount - 16'd1);
    assign checkSum = checksum + in_Byte_8;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            wordCount       <= '0;
            wordIndex       <= '0;
            byteCount       <= '0;
            wordShift       <= '0;
            checksum        <= '0;
            o_ByteReady     <= 1'b0;
            o_MemWrite      <= 1'b0;
            o_MemAddress_dw <= '0;
            o_MemData_dw    <= '0;
            o_CoreReset     <= 1'b0;
            o_Busy          <= 1'b0;
            o_Done          <= 1'b0;
            o_Error         <= 1'b0;
        end else begin
            state       <= stateNext;
            o_ByteReady <= readyNext;
            o_Busy      <= busyNext;
            o_Done      <= doneNext;
            o_Error     <= errorNext;
            o_CoreReset <= coreResetNext;
            o_MemWrite  <= 1'b0;
            case (state)
                IDLE, DONE, ERROR: begin
                    if (in_Start) begin
                        wordCount <= '0;
                        wordIndex <= '0;
                        byteCount <= '0;
                        wordShift <= '0;
                        checksum  <= '0;
                    end
                end
                LEN_HI: if (byteTake) wordCount[15:8] <= in_Byte_8;
                LEN_LO: begin
                    if (byteTake) begin
                        wordCount[7:0] <= in_Byte_8;
                        wordIndex      <= '0;
                        byteCount      <= '0;
                    end
                end
                DATA: begin
                    if (byteTake) begin
                        checksum  <= checksum + in_Byte_8;
                        byteCount <= byteCount + 2'd1;
                        // Fourth byte completes the word: write it out next cycle.
                        if (byteCount == 2'd3) begin
                            o_MemWrite      <= 1'b1;
                            o_MemData_dw    <= {wordShift, in_Byte_8};
                            o_MemAddress_dw <= {30'(wordIndex), 2'b00};
                            wordIndex       <= wordIndex + 1'b1;
                        end else begin
                            wordShift <= {wordShift[15:0], in_Byte_8};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:   if (in_Start) stateNext = LEN_HI;
            LEN_HI: if (byteTake) stateNext = LEN_LO;
            LEN_LO: begin
                if (byteTake) begin
                    if (lenFull > MAX_LEN)      stateNext = ERROR;
                    else if (lenFull == 16'd0)  stateNext = CHECK;
                    else                        stateNext = DATA;
                end
            end
            DATA:   if (byteTake && byteCount == 2'd3 && lastWord) stateNext = CHECK;
            CHECK:  if (byteTake) stateNext = (checkSum == 8'h00) ? DONE : ERROR;
            DONE:   if (in_Start) stateNext = LEN_HI;
            ERROR:  if (in_Start) stateNext = LEN_HI;
            default: stateNext = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register in step with it.
    always_comb begin
        readyNext     = 1'b0;
        busyNext      = 1'b0;
        doneNext      = 1'b0;
        errorNext     = 1'b0;
        coreResetNext = 1'b0;
        case (stateNext)
            LEN_HI, LEN_LO, DATA, CHECK: begin
                readyNext = 1'b1;
                busyNext  = 1'b1;
            end
            DONE: begin
                doneNext      = 1'b1;
                coreResetNext = 1'b1;
            end
            ERROR:   errorNext = 1'b1;
            default: ;
        endcase
    end

endmodule
